// File: rtl/gals_pkg.sv
// Shared encodings for the GALS emitter: top/channel FSM states and the
// channel index width helper.
package gals_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ARMED,
    T_COMPLETE,
    T_ERROR
  } top_state_e;

  typedef enum logic [1:0] {
    C_IDLE,
    C_REQ,
    C_REL,
    C_DONE
  } ch_state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gals_done_channel.sv
// One four-phase "neuron done" handshake channel toward the collector domain.
// The ack is synchronized locally; complete holds until the next step clears it.
module gals_done_channel
  import gals_pkg::*;
(
  input  logic local_clk,
  input  logic rst,
  input  logic clr,
  input  logic abort,
  input  logic armed,
  input  logic pe_done,
  input  logic ack_async,
  output logic req,
  output logic complete,
  output logic progress
);

  ch_state_e state;
  logic      ack_s1;
  logic      ack_sync;
  logic      pending;

  // Flags a state change this cycle; feeds the no-progress watchdog.
  always_comb begin
    progress = 1'b0;
    case (state)
      C_IDLE:  progress = pending;
      C_REQ:   progress = ack_sync;
      C_REL:   progress = ~ack_sync;
      default: progress = 1'b0;
    endcase
  end

  always_ff @(posedge local_clk) begin
    if (rst) begin
      state    <= C_IDLE;
      ack_s1   <= 1'b0;
      ack_sync <= 1'b0;
      pending  <= 1'b0;
      req      <= 1'b0;
      complete <= 1'b0;
    end else begin
      ack_s1   <= ack_async;
      ack_sync <= ack_s1;
      if (clr || abort) begin
        state    <= C_IDLE;
        pending  <= 1'b0;
        req      <= 1'b0;
        complete <= 1'b0;
      end else begin
        // Only the first pulse of a step counts; later ones find state != C_IDLE.
        if (armed && pe_done && state == C_IDLE)
          pending <= 1'b1;
        case (state)
          C_IDLE: if (pending) begin
            state <= C_REQ;
            req   <= 1'b1;
          end
          C_REQ: if (ack_sync) begin
            state <= C_REL;
            req   <= 1'b0;
          end
          C_REL: if (!ack_sync) begin
            state    <= C_DONE;
            complete <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/gals_emitter_unit.sv
// Step-level emitter: global request/ack to the collector plus OUT_NEURONS
// per-neuron done handshakes. Optional watchdog: GALS_EMITTER_WATCHDOG_EN.
module gals_emitter_unit
  import gals_pkg::*;
#(
  parameter int OUT_NEURONS      = 64,
  parameter int WATCHDOG_TIMEOUT = 16384
) (
  input  logic                   local_clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [OUT_NEURONS-1:0] i_pe_done,
  output logic                   o_aer_req,
  input  logic                   i_aer_ack,
  output logic [OUT_NEURONS-1:0] o_pe_done_req_vec,
  input  logic [OUT_NEURONS-1:0] i_pe_done_ack_vec,
  output logic                   o_step_done,
  output logic                   o_error,
  output logic                   o_busy
);

  localparam int IDX_W = idx_w(OUT_NEURONS);

  top_state_e             state;
  logic                   gack_s1, gack_sync, gack_dly;
  logic                   gack_edge;
  logic                   gack_seen;
  logic                   armed;
  logic                   step_clr;
  logic                   ch_abort;
  logic                   wd_trip;
  logic [OUT_NEURONS-1:0] complete;
  logic [OUT_NEURONS-1:0] progress;

  assign gack_edge = gack_sync & ~gack_dly;
  assign armed     = (state == T_ARMED);
  assign step_clr  = (state == T_IDLE) && i_start;
  // Requests drop on the same edge the watchdog fires.
  assign ch_abort  = wd_trip || (state == T_ERROR);

  for (genvar i = 0; i < OUT_NEURONS; i++) begin : g_ch
    gals_done_channel u_ch (
      .local_clk (local_clk),
      .rst       (rst),
      .clr       (step_clr),
      .abort     (ch_abort),
      .armed     (armed),
      .pe_done   (i_pe_done[i]),
      .ack_async (i_pe_done_ack_vec[i]),
      .req       (o_pe_done_req_vec[i]),
      .complete  (complete[i]),
      .progress  (progress[i])
    );
  end

  logic unused_idx;
  assign unused_idx = (IDX_W == 0);

`ifdef GALS_EMITTER_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_prog;

  assign wd_prog = (|progress) || gack_edge;
  assign wd_trip = armed && !wd_prog && (wd_cnt == WD_W'(WATCHDOG_TIMEOUT - 1));

  always_ff @(posedge local_clk) begin
    if (rst || !armed || wd_prog) wd_cnt <= '0;
    else                          wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic unused_wd;
  assign wd_trip   = 1'b0;
  assign unused_wd = (^progress) ^ (WATCHDOG_TIMEOUT == 0);
`endif

  always_ff @(posedge local_clk) begin
    if (rst) begin
      state       <= T_IDLE;
      gack_s1     <= 1'b0;
      gack_sync   <= 1'b0;
      gack_dly    <= 1'b0;
      gack_seen   <= 1'b0;
      o_aer_req   <= 1'b0;
      o_step_done <= 1'b0;
      o_error     <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      gack_s1     <= i_aer_ack;
      gack_sync   <= gack_s1;
      gack_dly    <= gack_sync;
      o_step_done <= 1'b0;
      case (state)
        T_IDLE: if (i_start) begin
          state     <= T_ARMED;
          gack_seen <= 1'b0;
          o_aer_req <= 1'b1;
          o_busy    <= 1'b1;
        end
        T_ARMED: begin
          if (wd_trip) begin
            state     <= T_ERROR;
            o_error   <= 1'b1;
            o_aer_req <= 1'b0;
          end else if ((&complete) && gack_seen) begin
            state       <= T_COMPLETE;
            o_step_done <= 1'b1;
            o_aer_req   <= 1'b0;
          end else if (gack_edge) begin
            gack_seen <= 1'b1;
            o_aer_req <= 1'b0;
          end
        end
        T_COMPLETE: begin
          state  <= T_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          o_error   <= 1'b1;
          o_aer_req <= 1'b0;
          o_busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gals_emitter_unit.sv
// Bench for gals_emitter_unit (4 channels): table of step scenarios plus
// hand sequences; req rises are scoreboarded against a queue of expected channels.
module tb_gals_emitter_unit;
  localparam int N = 4;

  logic         local_clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [N-1:0] i_pe_done = '0;
  logic         i_aer_ack = 1'b0;
  logic [N-1:0] i_pe_done_ack_vec;
  logic [N-1:0] o_pe_done_req_vec;
  logic         o_aer_req, o_step_done, o_error, o_busy;

  always #5 local_clk = ~local_clk;

  gals_emitter_unit #(.OUT_NEURONS(N), .WATCHDOG_TIMEOUT(32)) dut (
    .local_clk         (local_clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_pe_done         (i_pe_done),
    .o_aer_req         (o_aer_req),
    .i_aer_ack         (i_aer_ack),
    .o_pe_done_req_vec (o_pe_done_req_vec),
    .i_pe_done_ack_vec (i_pe_done_ack_vec),
    .o_step_done       (o_step_done),
    .o_error           (o_error),
    .o_busy            (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge local_clk) cyc++;

  // Collector model: each ack mirrors its request three cycles later.
  logic [N-1:0] dly0 = '0, dly1 = '0, dly2 = '0, hold = '0;
  always @(posedge local_clk) begin
    dly2 <= dly1;
    dly1 <= dly0;
    dly0 <= o_pe_done_req_vec;
  end
  assign i_pe_done_ack_vec = dly2 & ~hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ch;
    int cyc;
  } exp_t;
  exp_t         sbq[$];
  logic [N-1:0] fired = '0;
  bit           armed_m = 1'b0;

  int           hs_cnt[N] = '{default: 0};
  int           sd_cnt = 0;
  logic [N-1:0] prev_req = '0;

  always @(negedge local_clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (o_pe_done_req_vec[i] === 1'b1 && prev_req[i] !== 1'b1) begin
        hs_cnt[i]++;
        if (sbq.size() == 0) check("unexpected_req_rise", i, 32'hff);
        else begin
          e = sbq.pop_front();
          check("req_rise_chan", i, e.ch);
          check("req_rise_latency", cyc - e.cyc, 2);
        end
      end
    end
    if (o_step_done === 1'b1) sd_cnt++;
    prev_req = o_pe_done_req_vec;
  end

  typedef struct {
    logic [N-1:0] a, b, c, hold;
    bit           early, restart;
    logic [N-1:0] exp_hs;
  } vec_t;
  vec_t tbl[4];

  task automatic pulse_done(input logic [N-1:0] mask);
    i_pe_done = mask;
    for (int i = 0; i < N; i++)
      if (armed_m && mask[i] && !fired[i]) begin
        sbq.push_back('{ch: i, cyc: cyc});
        fired[i] = 1'b1;
      end
    @(negedge local_clk);
    i_pe_done = '0;
  endtask

  task automatic start_step();
    i_start = 1'b1;
    armed_m = 1'b1;
    fired   = '0;
    @(negedge local_clk);
    i_start = 1'b0;
    check("aer_req_after_start", o_aer_req, 1);
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic gack_pulse();
    i_aer_ack = 1'b1;
    @(negedge local_clk);
    i_aer_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge local_clk);
    check("rst_aer_req", o_aer_req, 0);
    check("rst_req_vec", o_pe_done_req_vec, 0);
    check("rst_busy", o_busy, 0);
    check("rst_step_done", o_step_done, 0);
    check("rst_error", o_error, 0);
    repeat (2) @(negedge local_clk);
    rst = 1'b0;
    sbq.delete();
    armed_m = 1'b0;
    fired = '0;
    hold = '0;
    repeat (8) @(negedge local_clk);
  endtask

  task automatic run_step(input vec_t v);
    int sd0;
    int hs0[N];
    sd0  = sd_cnt;
    hs0  = hs_cnt;
    hold = v.hold;
    start_step();
    repeat (2) @(negedge local_clk);
    pulse_done(v.a);
    repeat (3) @(negedge local_clk);
    pulse_done(v.b);
    repeat (30) @(negedge local_clk);
    if (v.restart) begin
      i_start = 1'b1;
      @(negedge local_clk);
      i_start = 1'b0;
    end
    pulse_done(v.c);
    gack_pulse();
    if (v.early) begin
      repeat (5) @(negedge local_clk);
      check("early_gack_aer_req", o_aer_req, 0);
      check("early_gack_no_done", sd_cnt - sd0, 0);
      check("early_gack_busy", o_busy, 1);
      hold = '0;
    end
    for (int k = 0; k < 80 && sd_cnt == sd0; k++) @(negedge local_clk);
    repeat (3) @(negedge local_clk);
    check("step_done_pulses", sd_cnt - sd0, 1);
    check("idle_busy", o_busy, 0);
    check("idle_aer_req", o_aer_req, 0);
    check("idle_req_vec", o_pe_done_req_vec, 0);
    for (int i = 0; i < N; i++) check("handshakes_per_chan", hs_cnt[i] - hs0[i], v.exp_hs[i]);
    check("scoreboard_drained", sbq.size(), 0);
    armed_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{a: 4'b1111, b: 4'b0000, c: 4'b0000, hold: 4'b0000, early: 0, restart: 0, exp_hs: 4'b1111};
    tbl[1] = '{a: 4'b1111, b: 4'b0000, c: 4'b0000, hold: 4'b0100, early: 1, restart: 0, exp_hs: 4'b1111};
    tbl[2] = '{a: 4'b0010, b: 4'b1111, c: 4'b0010, hold: 4'b0000, early: 0, restart: 0, exp_hs: 4'b1111};
    tbl[3] = '{a: 4'b0101, b: 4'b0000, c: 4'b1010, hold: 4'b0000, early: 0, restart: 1, exp_hs: 4'b1111};

    repeat (3) @(negedge local_clk);
    check("reset_aer_req", o_aer_req, 0);
    check("reset_req_vec", o_pe_done_req_vec, 0);
    check("reset_step_done", o_step_done, 0);
    check("reset_error", o_error, 0);
    check("reset_busy", o_busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge local_clk);

    // Done pulses while idle must be dropped.
    pulse_done(4'b1111);
    repeat (5) @(negedge local_clk);
    check("idle_pulse_dropped", o_pe_done_req_vec, 0);

    for (int t = 0; t < 4; t++) run_step(tbl[t]);

    // Reset in the middle of a step with every channel requesting.
    start_step();
    repeat (2) @(negedge local_clk);
    pulse_done(4'b1111);
    @(negedge local_clk);
    check("midstep_reqs_up", o_pe_done_req_vec, 4'b1111);
    do_reset();
    run_step(tbl[0]);

`ifdef GALS_EMITTER_WATCHDOG_EN
    begin
      int tf;
      hold = 4'b0001;
      start_step();
      repeat (2) @(negedge local_clk);
      pulse_done(4'b1111);
      repeat (3) @(negedge local_clk);
      for (int k = 0; k < 40 && o_pe_done_req_vec[3:1] != 3'b000; k++) @(negedge local_clk);
      tf = cyc;
      while (cyc < tf + 34) @(negedge local_clk);
      check("wd_not_yet", o_error, 0);
      while (cyc < tf + 42) @(negedge local_clk);
      check("wd_error", o_error, 1);
      check("wd_req_vec", o_pe_done_req_vec, 0);
      check("wd_aer_req", o_aer_req, 0);
      check("wd_busy", o_busy, 1);
      do_reset();
      check("wd_cleared", o_error, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
